// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipe.
package reg_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic stage: a data register plus its valid bit.
// Optional preset input when ELASTIC_REG_PIPE_PRESET_EN is defined.
module reg_pipe_stage #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
`ifdef ELASTIC_REG_PIPE_PRESET_EN
  , parameter logic [WIDTH-1:0] PRESET_VALUE = '1
`endif
) (
  input  logic             clk_i,
  input  logic             clr_i,
`ifdef ELASTIC_REG_PIPE_PRESET_EN
  input  logic             preset_i,
`endif
  input  logic             rdy_i,
  input  logic             up_vld_i,
  input  logic [WIDTH-1:0] up_dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o,
  output logic             vld_d_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  // Load from upstream when ready; data only moves with a valid word so
  // the register keeps the last delivered value once the pipe drains.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rdy_i) begin
      vld_d = up_vld_i;
      if (up_vld_i) dat_d = up_dat_i;
    end
  end

  // State register; clear beats preset.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VALUE;
    end
`ifdef ELASTIC_REG_PIPE_PRESET_EN
    else if (preset_i) begin
      vld_q <= 1'b1;
      dat_q <= PRESET_VALUE;
    end
`endif
    else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o   = vld_q;
  assign dat_o   = dat_q;
  assign vld_d_o = vld_d;

endmodule

// File: rtl/elastic_reg_pipe.sv
// Elastic register pipeline: DEPTH bubble-collapsing stages with a
// combinational ready chain and a registered occupancy count.
// Define ELASTIC_REG_PIPE_PRESET_EN to add the Preset input and PRESET_VALUE.
module elastic_reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
`ifdef ELASTIC_REG_PIPE_PRESET_EN
  , parameter logic [WIDTH-1:0] PRESET_VALUE = '1
`endif
) (
  input  logic                     Clock,
  input  logic                     Clr,
`ifdef ELASTIC_REG_PIPE_PRESET_EN
  input  logic                     Preset,
`endif
  input  logic [WIDTH-1:0]         D,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  output logic [WIDTH-1:0]         Q,
  output logic [WIDTH-1:0]         Q_bar,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [cnt_w(DEPTH)-1:0]  Count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH:0]            rdy;
  logic [DEPTH-1:0]          vld_q;
  logic [DEPTH-1:0]          vld_d;
  logic [DEPTH-1:0]          up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q;
  logic [DEPTH-1:0][WIDTH-1:0] up_dat;
  logic [CW-1:0]             count_q, count_d;

  assign rdy[DEPTH] = Out_Ready;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      // A stage can take a word if it is empty or its occupant moves on.
      assign rdy[i] = ~vld_q[i] | rdy[i+1];

      if (i == 0) begin : g_head
        assign up_vld[i] = In_Valid;
        assign up_dat[i] = D;
      end else begin : g_body
        assign up_vld[i] = vld_q[i-1];
        assign up_dat[i] = dat_q[i-1];
      end

      reg_pipe_stage #(
        .WIDTH        (WIDTH),
        .RESET_VALUE  (RESET_VALUE)
`ifdef ELASTIC_REG_PIPE_PRESET_EN
        , .PRESET_VALUE (PRESET_VALUE)
`endif
      ) u_stage (
        .clk_i    (Clock),
        .clr_i    (Clr),
`ifdef ELASTIC_REG_PIPE_PRESET_EN
        .preset_i (Preset),
`endif
        .rdy_i    (rdy[i]),
        .up_vld_i (up_vld[i]),
        .up_dat_i (up_dat[i]),
        .vld_o    (vld_q[i]),
        .dat_o    (dat_q[i]),
        .vld_d_o  (vld_d[i])
      );
    end
  endgenerate

  // Population of the next-state valid bits, so Count tracks v[] exactly.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld_d[k]) count_d = count_d + CW'(1);
    end
  end

  // Occupancy register with the same clear/preset priority as the stages.
  always_ff @(posedge Clock) begin
    if (Clr)         count_q <= '0;
`ifdef ELASTIC_REG_PIPE_PRESET_EN
    else if (Preset) count_q <= CW'(DEPTH);
`endif
    else             count_q <= count_d;
  end

  assign In_Ready  = rdy[0];
  assign Q         = dat_q[DEPTH-1];
  assign Q_bar     = ~dat_q[DEPTH-1];
  assign Out_Valid = vld_q[DEPTH-1];
  assign Count     = count_q;

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Scoreboard bench for elastic_reg_pipe (WIDTH=8, DEPTH=3).
module tb_elastic_reg_pipe;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         preset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] d = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] q, q_bar;
  logic [1:0]   count;

  always #5 clk = ~clk;

  elastic_reg_pipe #(
    .WIDTH       (W),
    .DEPTH       (D),
    .RESET_VALUE (8'h00)
`ifdef ELASTIC_REG_PIPE_PRESET_EN
    , .PRESET_VALUE (8'hFF)
`endif
  ) dut (
    .Clock     (clk),
    .Clr       (clr),
`ifdef ELASTIC_REG_PIPE_PRESET_EN
    .Preset    (preset),
`endif
    .D         (d),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .Q         (q),
    .Q_bar     (q_bar),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Count     (count)
  );

  int           n_chk = 0;
  int           n_fail = 0;
  int           pops = 0;
  bit           acc;
  logic [W-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Sample handshakes mid-cycle, advance one edge, update the scoreboard.
  task automatic tick();
    bit           c, p, hs_in, hs_out;
    logic [W-1:0] dv;
    #1;
    c      = (clr === 1'b1);
    p      = (preset === 1'b1);
    hs_in  = (in_valid === 1'b1) && (in_ready === 1'b1);
    hs_out = (out_valid === 1'b1) && (out_ready === 1'b1);
    dv     = d;
    acc    = hs_in && !c && !p;
    if (count === 2'(D)) chk("full_rdy", {31'd0, in_ready}, {31'd0, out_ready});
    if (hs_out && !c && !p) begin
      if (sb.size() == 0) chk("spurious_pop", sb.size(), 1);
      else begin
        chk("sb_data", {24'd0, q}, {24'd0, sb.pop_front()});
        pops++;
      end
    end
    @(posedge clk);
    #1;
    if (c) sb.delete();
    else if (p) begin
      sb.delete();
      repeat (D) sb.push_back(8'hFF);
    end else if (acc) sb.push_back(dv);
    chk("count", {30'd0, count}, sb.size());
  endtask

  logic [W-1:0] vals[4];
  int           idx;
  int           ir_drop;
  bit           seen;

  initial begin
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset with a word offered: it must be discarded.
    clr = 1'b1; in_valid = 1'b1; d = 8'hAB;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_ov",   {31'd0, out_valid}, 0);
    chk("rst_q",    {24'd0, q}, 32'h00);
    chk("rst_qbar", {24'd0, q_bar}, 32'hFF);
    chk("rst_cnt",  {30'd0, count}, 0);
    chk("rst_ir",   {31'd0, in_ready}, 1);

    // Back-to-back, unstalled: latency DEPTH, then one per cycle.
    out_ready = 1'b1; in_valid = 1'b1;
    d = 8'h11; tick();
    d = 8'h22; tick();
    d = 8'h33; tick();
    chk("lat_ov", {31'd0, out_valid}, 1);
    chk("lat_q",  {24'd0, q}, 32'h11);
    in_valid = 1'b0;
    tick(); chk("b2b_q2", {24'd0, q}, 32'h22);
    tick(); chk("b2b_q3", {24'd0, q}, 32'h33);
    tick();
    chk("drain_ov", {31'd0, out_valid}, 0);
    chk("drain_q",  {24'd0, q}, 32'h33);

    // Stalled fill, then simultaneous leave/accept when full.
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    for (int k = 0; k < 6; k++) begin
      d = vals[idx];
      tick();
      if (acc) idx++;
    end
    chk("fill_n",   idx, 3);
    chk("full_ir",  {31'd0, in_ready}, 0);
    chk("full_cnt", {30'd0, count}, 3);
    chk("full_q",   {24'd0, q}, 32'h11);
    out_ready = 1'b1;
    #1;
    chk("full_ir_or", {31'd0, in_ready}, 1);
    tick();
    chk("full_acc",  {31'd0, acc}, 1);
    chk("full_q2",   {24'd0, q}, 32'h22);
    chk("full_cnt2", {30'd0, count}, 3);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("fill_drain_q",   {24'd0, q}, 32'h44);
    chk("fill_drain_cnt", {30'd0, count}, 0);

    // Single word collapses through bubbles while stalled.
    out_ready = 1'b0; in_valid = 1'b1; d = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("bub_ov",  {31'd0, out_valid}, 1);
    chk("bub_q",   {24'd0, q}, 32'h5A);
    chk("bub_cnt", {30'd0, count}, 1);
    chk("bub_ir",  {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    d = 8'h66; tick();
    d = 8'h77; tick();
    in_valid = 1'b0;
    chk("bub_full", {30'd0, count}, 3);
    out_ready = 1'b1;
    repeat (4) tick();

    // Clear mid-stream: in-flight and offered words vanish.
    out_ready = 1'b0; in_valid = 1'b1;
    d = 8'h81; tick();
    d = 8'h82; tick();
    clr = 1'b1; d = 8'h99; tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_cnt", {30'd0, count}, 0);
    chk("clr_ov",  {31'd0, out_valid}, 0);
    chk("clr_ir",  {31'd0, in_ready}, 1);
    chk("clr_q",   {24'd0, q}, 32'h00);
    out_ready = 1'b1; seen = 1'b0;
    repeat (5) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    chk("clr_no_emerge", {31'd0, seen}, 0);

    // Full throughput.
    pops = 0; ir_drop = 0; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d = W'($urandom);
      #1;
      if (in_ready !== 1'b1) ir_drop++;
      tick();
    end
    in_valid = 1'b0;
    repeat (D) tick();
    chk("tput_pops", pops, 20);
    chk("tput_ir",   ir_drop, 0);

    // Random valid/ready traffic.
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      d         = W'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (D + 1) tick();
    chk("rand_empty", sb.size(), 0);

`ifdef ELASTIC_REG_PIPE_PRESET_EN
    out_ready = 1'b0; preset = 1'b1; in_valid = 1'b1; d = 8'h12;
    tick();
    preset = 1'b0; in_valid = 1'b0;
    chk("pre_cnt",  {30'd0, count}, 3);
    chk("pre_q",    {24'd0, q}, 32'hFF);
    chk("pre_qbar", {24'd0, q_bar}, 32'h00);
    chk("pre_ov",   {31'd0, out_valid}, 1);
    clr = 1'b1; preset = 1'b1;
    tick();
    clr = 1'b0; preset = 1'b0;
    chk("prio_cnt", {30'd0, count}, 0);
    chk("prio_q",   {24'd0, q}, 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
